// File: rtl/pu_weight_sram_arbiter.sv
// pu_weight_sram_arbiter
// Shares one weight-SRAM read port among NUM_PU weight buffers. Requests are
// served round-robin, one at a time. The captured word is held with a one-hot
// ready until the granted PU consumes it or withdraws its request.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no transaction; arbitrate among pending requests
// ST_ISSUE   | sram_rd_en high for this single cycle; latency timer loaded
// ST_WAIT    | timer counts down; capture read data at terminal count
// ST_RESPOND | ready/data held until consume (enable) or withdraw (read low)
module pu_weight_sram_arbiter #(
  parameter int NUM_PU          = 4,
  parameter int WEIGHT_SRAM_LEN = 64,
  parameter int ADDR_W          = 32,
  parameter int SRAM_LAT        = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PU-1:0]            pu_word_read,
  input  logic [NUM_PU*ADDR_W-1:0]     pu_word_counter,
  input  logic [NUM_PU*ADDR_W-1:0]     pu_base_addr,
  input  logic [NUM_PU-1:0]            pu_enable,
  output logic [NUM_PU-1:0]            pu_word_ready,
  output logic [WEIGHT_SRAM_LEN-1:0]   pu_SRAM_in,
  output logic                         sram_rd_en,
  output logic [ADDR_W-1:0]            sram_addr,
  input  logic [WEIGHT_SRAM_LEN-1:0]   sram_rd_data,
  output logic [$clog2(NUM_PU)-1:0]    grant_id,
  output logic                         busy
);

  localparam int GW = $clog2(NUM_PU);
  // Timer holds SRAM_LAT-1 down to 0; keep at least one bit when SRAM_LAT is 1.
  localparam int CW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t                       state_q, state_d;
  logic [GW-1:0]                grant_q, grant_d;
  logic [GW-1:0]                last_q, last_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic                         rd_en_q, rd_en_d;
  logic [NUM_PU-1:0]            ready_q, ready_d;
  logic [WEIGHT_SRAM_LEN-1:0]   data_q, data_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         busy_q, busy_d;

  logic                         arb_found;
  logic [GW-1:0]                arb_idx;
  logic [GW-1:0]                cand;
  logic [ADDR_W-1:0]            arb_base;
  logic [ADDR_W-1:0]            arb_ctr;

  // Round-robin pick: first pending request scanning upward from last_grant+1.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= NUM_PU; k++) begin
      cand = GW'((int'(last_q) + k) % NUM_PU);
      if (!arb_found && pu_word_read[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    arb_base = pu_base_addr[arb_idx*ADDR_W +: ADDR_W];
    arb_ctr  = pu_word_counter[arb_idx*ADDR_W +: ADDR_W];
  end

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    ready_d = ready_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          last_d  = arb_idx;
          // Carry out of the address sum is intentionally dropped (wraps).
          addr_d  = arb_base + arb_ctr;
          rd_en_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CW'(SRAM_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = sram_rd_data;
          ready_d = NUM_PU'(1) << grant_q;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESPOND: begin
        // Consume takes priority; a withdrawn request drops the word.
        if (pu_enable[grant_q] || !pu_word_read[grant_q]) begin
          ready_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ready_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_PU - 1);
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      ready_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign pu_word_ready = ready_q;
  assign pu_SRAM_in    = data_q;
  assign sram_rd_en    = rd_en_q;
  assign sram_addr     = addr_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;

endmodule
